// File: rtl/bit_stream_controller_if.sv
// Handshake and serial-bit bundle between an upstream word source, bit_stream_controller
// and the downstream bit_selector.
interface bit_stream_controller_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_ready;
    logic [15:0] word_out;
    logic [3:0]  bit_idx;
    logic        lock;
    logic        bit_valid;
    logic        word_last;
    logic        busy;

    // Valid/ready: a word transfers on every rising edge where in_valid && in_ready;
    // the source holds in_data stable while in_valid is high and in_ready is low, and
    // a bit is consumed on every rising edge where bit_valid && out_ready.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, word_out, bit_idx, lock, bit_valid, word_last, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, word_out, bit_idx, lock, bit_valid, word_last, busy
    );
endinterface

// File: rtl/bit_stream_controller.sv
// Serializes 16-bit words MSB first as (word_out, bit_idx) pairs for bit_selector.
// Define BIT_STREAM_DOUBLE_BUF_EN to add a one-entry pending word for bubble-free streaming.
module bit_stream_controller (
    input  logic                     clk,
    input  logic                     rst_n,
    bit_stream_controller_if.slave   bus,
    output logic                     state_dbg_o
);
    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] word_q, word_d;
    logic [3:0]  idx_q, idx_d;
    logic        in_ready;
    logic        accept;
    logic        consume;
    logic        last_bit;

`ifdef BIT_STREAM_DOUBLE_BUF_EN
    logic [15:0] pend_q, pend_d;
    logic        pend_v_q, pend_v_d;

    assign in_ready = !pend_v_q;
`else
    assign in_ready = (state_q == IDLE);
`endif

    assign accept   = bus.in_valid && in_ready;
    assign consume  = (state_q == STREAM) && bus.out_ready;
    assign last_bit = consume && (idx_q == 4'hF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            word_q   <= 16'h0000;
            idx_q    <= 4'hF;
`ifdef BIT_STREAM_DOUBLE_BUF_EN
            pend_q   <= 16'h0000;
            pend_v_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            idx_q    <= idx_d;
`ifdef BIT_STREAM_DOUBLE_BUF_EN
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        idx_d    = idx_q;
`ifdef BIT_STREAM_DOUBLE_BUF_EN
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    word_d  = bus.in_data;
                    idx_d   = 4'h0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (last_bit) begin
`ifdef BIT_STREAM_DOUBLE_BUF_EN
                    if (pend_v_q) begin
                        word_d   = pend_q;
                        idx_d    = 4'h0;
                        pend_v_d = 1'b0;
                    end else if (accept) begin
                        // Word arriving on the last bit bypasses the empty pending slot.
                        word_d = bus.in_data;
                        idx_d  = 4'h0;
                    end else begin
                        state_d = IDLE;
                        idx_d   = 4'hF;
                    end
`else
                    // Parks at F rather than wrapping to 0 so bit_selector sees an idle index.
                    state_d = IDLE;
                    idx_d   = 4'hF;
`endif
                end else begin
                    if (consume) begin
                        idx_d = idx_q + 4'd1;
                    end
`ifdef BIT_STREAM_DOUBLE_BUF_EN
                    if (accept) begin
                        pend_d   = bus.in_data;
                        pend_v_d = 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = 4'hF;
            end
        endcase
    end

    assign bus.in_ready  = in_ready;
    assign bus.word_out  = word_q;
    assign bus.bit_idx   = idx_q;
    assign bus.bit_valid = (state_q == STREAM);
    assign bus.lock      = (state_q != STREAM);
    assign bus.word_last = (state_q == STREAM) && (idx_q == 4'hF);
`ifdef BIT_STREAM_DOUBLE_BUF_EN
    assign bus.busy      = (state_q == STREAM) || pend_v_q;
`else
    assign bus.busy      = (state_q == STREAM);
`endif
    assign state_dbg_o   = state_q;
endmodule

// File: tb/tb_bit_stream_controller.sv
// Self-checking bench for bit_stream_controller: a scoreboard of expected
// {word_last, bit} pairs plus directed timing checks for both buffer builds.
module tb_bit_stream_controller;
    logic clk = 1'b0;
    logic rst_n;
    logic state_dbg;

    always #5 clk = ~clk;

    bit_stream_controller_if bus ();

    bit_stream_controller dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .state_dbg_o (state_dbg)
    );

    int         total = 0;
    int         bad   = 0;
    logic [1:0] exp_q[$];
    logic [1:0] mon_e;
    int         w;
    int         c;
    int         n;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [15:0] d);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back({1'(i == 15), d[15 - i]});
        end
    endtask

    // Holds in_valid until the block accepts; returns with the accept edge just past.
    task automatic send_word(input logic [15:0] d, output int waited);
        waited = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (!bus.in_ready && waited < 100) begin
            step();
            waited++;
        end
        if (!bus.in_ready) begin
            check_val("accept_timeout", 32'(bus.in_ready), 1);
            bus.in_valid = 1'b0;
        end else begin
            push_word(d);
            step();
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic wait_idx(input logic [3:0] target);
        int k;
        k = 0;
        while (bus.bit_idx !== target && k < 100) begin
            step();
            k++;
        end
        check_val("wait_idx", 32'(bus.bit_idx), 32'(target));
    endtask

    task automatic run_len(output int len);
        len = 0;
        while (bus.bit_valid && len < 100) begin
            step();
            len++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_lock"},      32'(bus.lock),      1);
        check_val({tag, "_bit_idx"},   32'(bus.bit_idx),   32'hF);
        check_val({tag, "_bit_valid"}, 32'(bus.bit_valid), 0);
        check_val({tag, "_in_ready"},  32'(bus.in_ready),  1);
        check_val({tag, "_word_out"},  32'(bus.word_out),  32'h0000);
        check_val({tag, "_busy"},      32'(bus.busy),      0);
        check_val({tag, "_word_last"}, 32'(bus.word_last), 0);
        check_val({tag, "_state"},     32'(state_dbg),     0);
    endtask

    // Scoreboard: every consumed bit must match the next expected {word_last, bit}.
    always @(negedge clk) begin
        if (rst_n && bus.bit_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check_val("extra_bit", 32'(bus.bit_idx), 32'hDEAD);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("stream_bit", 32'({bus.word_last, bus.word_out[4'hF - bus.bit_idx]}), 32'(mon_e));
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'h0000;
        bus.out_ready = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (5) step();
        check_reset_outputs("idle");

        // Single word: latency, 16-cycle length, lock on the following cycle.
        send_word(16'hACF0, w);
        check_val("lat_bit_valid", 32'(bus.bit_valid), 1);
        check_val("lat_bit_idx",   32'(bus.bit_idx),   0);
        check_val("lat_word_out",  32'(bus.word_out),  32'hACF0);
        check_val("lat_lock",      32'(bus.lock),      0);
        c = 1;
        while (!bus.word_last && c < 100) begin
            step();
            c++;
        end
        check_val("single_len", 32'(c), 16);
        step();
        check_val("single_lock_after", 32'(bus.lock),      1);
        check_val("single_idle_valid", 32'(bus.bit_valid), 0);
        check_val("single_idle_idx",   32'(bus.bit_idx),   32'hF);

        // Backpressure: three stalled cycles at bit_idx 5.
        step();
        send_word(16'h530F, w);
        c = 1;
        while (bus.bit_idx !== 4'h5 && c < 100) begin
            step();
            c++;
        end
        check_val("bp_reach_5", 32'(bus.bit_idx), 5);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            c++;
            check_val("bp_hold_idx",   32'(bus.bit_idx),   5);
            check_val("bp_hold_valid", 32'(bus.bit_valid), 1);
        end
        bus.out_ready = 1'b1;
        while (!bus.word_last && c < 100) begin
            step();
            c++;
        end
        check_val("bp_len", 32'(c), 19);
        step();

        // Back-to-back words with in_valid and out_ready held high.
        step();
        send_word(16'hACF0, w);
`ifdef BIT_STREAM_DOUBLE_BUF_EN
        check_val("b2b_ready_first", 32'(bus.in_ready), 1);
        send_word(16'h530F, w);
        check_val("b2b_wait", 32'(w), 0);
        check_val("b2b_ready_pending", 32'(bus.in_ready), 0);
        check_val("b2b_busy", 32'(bus.busy), 1);
        repeat (15) step();
        check_val("b2b_ready_back", 32'(bus.in_ready), 1);
        check_val("b2b_idx2",       32'(bus.bit_idx),  0);
        check_val("b2b_word2",      32'(bus.word_out), 32'h530F);
        check_val("b2b_valid2",     32'(bus.bit_valid), 1);
        run_len(n);
        check_val("b2b_run2", 32'(n), 16);
`else
        check_val("b2b_ready_stream", 32'(bus.in_ready), 0);
        send_word(16'h530F, w);
        check_val("b2b_wait", 32'(w), 16);
        check_val("b2b_valid2", 32'(bus.bit_valid), 1);
        check_val("b2b_idx2",   32'(bus.bit_idx),   0);
        check_val("b2b_word2",  32'(bus.word_out),  32'h530F);
        run_len(n);
        check_val("b2b_run2", 32'(n), 16);
`endif

`ifdef BIT_STREAM_DOUBLE_BUF_EN
        // Handshake on the same edge the last bit is consumed.
        step();
        send_word(16'hACF0, w);
        wait_idx(4'hF);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h1234;
        check_val("sim_ready_before", 32'(bus.in_ready), 1);
        push_word(16'h1234);
        step();
        bus.in_valid = 1'b0;
        check_val("sim_word",  32'(bus.word_out), 32'h1234);
        check_val("sim_idx",   32'(bus.bit_idx),  0);
        check_val("sim_busy",  32'(bus.busy),     1);
        check_val("sim_ready", 32'(bus.in_ready), 1);
        run_len(n);
        check_val("sim_run", 32'(n), 16);
`endif

        // Asynchronous reset in the middle of a word.
        step();
        send_word(16'hACF0, w);
        wait_idx(4'h7);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs("async_rst");
        repeat (2) step();
        rst_n = 1'b1;
        repeat (5) step();
        check_val("post_rst_valid", 32'(bus.bit_valid), 0);
        check_val("post_rst_state", 32'(state_dbg),     0);
        check_val("post_rst_word",  32'(bus.word_out),  0);
        send_word(16'h5A5A, w);
        run_len(n);
        check_val("post_rst_run", 32'(n), 16);

        step();
        check_val("queue_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bit_stream_controller.md
# bit_stream_controller

Upstream sequencer for `bit_selector` that turns 16-bit keystream/data words into a cycle-by-cycle serial bit stream. It accepts words over a valid/ready handshake and holds the current word on `word_out`. It drives the 4-bit index (`bit_idx`) and `lock` that `bit_selector` consumes, so bits emerge MSB first (index 0 selects bit 15). It applies downstream backpressure and reports word boundaries.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  upstream word available
- `in_ready`  out  1  block can accept a word this cycle
- `in_data`  in  16  word to serialize
- `out_ready`  in  1  downstream consumes the current bit this cycle
- `word_out`  out  16  word being streamed; feeds `bit_selector.data_in`
- `bit_idx`  out  4  bit index; feeds `bit_selector.clock_in`
- `lock`  out  1  high when no word is streaming; feeds `bit_selector.lock`
- `bit_valid`  out  1  `word_out` and `bit_idx` present a valid bit
- `word_last`  out  1  `bit_valid && bit_idx == 4'hF`
- `busy`  out  1  a word is streaming or a word is pending

## Operation
- States: IDLE and STREAM.
- **IDLE:**
  - `bit_valid=0`, `lock=1`, `bit_idx=4'hF`; `word_out` holds its last value.
  - On `in_valid && in_ready`: load `in_data` into `word_out`, set `bit_idx=0`, and go to STREAM.
- **STREAM:**
  - `bit_valid=1`, `lock=0`.
  - On `out_ready`: the bit is consumed and `bit_idx` increments by 1 (4-bit).
  - If `out_ready=0`, `bit_idx` and `word_out` hold.
- **Word end:** when the bit at `bit_idx==4'hF` is consumed:
  - If a next word is available (see Configuration), load it and set `bit_idx=0`, staying in STREAM.
  - Otherwise go to IDLE, with `bit_idx` wrapping to `4'hF` (not 0) and `lock=1`.
- **Handshake:**
  - `in_ready` depends only on registered state, never combinationally on `out_ready`.
  - `in_data` is sampled only on an `in_valid && in_ready` edge.
- **Outputs:** `word_last` and `busy` are combinational from state.
- **Reset values:** state IDLE, `word_out=16'h0000`, `bit_idx=4'hF`, `lock=1`, `bit_valid=0`, `word_last=0`, `busy=0`, `in_ready=1`, pending buffer empty.
- **Reset mid-word:** asserting `rst_n` low forces all reset values immediately (asynchronously). The partial word and any pending word are discarded; no word resumes after reset.

## Timing
- **Latency:** a word accepted at edge N has bit 15 valid (`bit_idx=0`) in the cycle after edge N.
- With `out_ready` held high, a word occupies exactly 16 consecutive `bit_valid` cycles. `word_last` is high on the 16th.
- Each `out_ready=0` cycle while `bit_valid=1` adds one cycle.
- **`in_valid` without `in_ready`:** no state change; upstream must hold `in_data` stable.

## Configuration
Macro: `BIT_STREAM_DOUBLE_BUF_EN`.
- **Undefined (single buffer):**
  - `in_ready = (state == IDLE)`.
  - There is exactly one IDLE (bubble) cycle between consecutive words, so throughput is 17 cycles/word with `out_ready` high.
  - `busy = (state == STREAM)`.
- **Defined (one-entry pending register):**
  - `in_ready = !pending_valid`.
  - A word accepted in IDLE goes directly to `word_out`.
  - A word accepted in STREAM goes to pending.
  - On last-bit consumption, pending moves into `word_out` with `bit_idx=0`; `pending_valid` clears and `in_ready` rises the following cycle.
  - **Simultaneous last-bit consume and input handshake with pending empty:** the incoming word loads directly into `word_out` with `bit_idx=0`, and pending stays empty.
  - Throughput is 16 cycles/word with no bubble.
  - `busy = (state == STREAM) || pending_valid`.

## Test plan
- **Reset/idle:** after `rst_n` deassert with `in_valid=0` for 5 cycles, expect `lock=1`, `bit_idx=F`, `bit_valid=0`, `in_ready=1`, `word_out=0000`.
- **Single word:** accept `16'hACF0` with `out_ready=1`.
  - `bit_selector` output sequence is 1,0,1,0,1,1,0,0,1,1,1,1,0,0,0,0.
  - `word_last` is high only on the 16th bit; `lock=1` the next cycle.
- **Backpressure:** on word `16'h530F`, drop `out_ready` for 3 cycles at `bit_idx=5`. Expect `bit_idx` to hold 5 and `bit_valid` to stay 1, with 19 total cycles to `word_last`.
- **Back-to-back:** present `16'hACF0` then `16'h530F` with `in_valid` and `out_ready` held high.
  - Without the macro: one `bit_valid=0` bubble between words, and `in_ready=0` throughout STREAM.
  - With the macro: 32 consecutive `bit_valid` cycles; `in_ready` goes low after the second accept and high again the cycle after the second word loads.
- **Simultaneous (macro defined):** assert `in_valid` with `16'h1234` in the same cycle the last bit of `16'hACF0` is consumed. Expect next cycle `word_out=1234`, `bit_idx=0`, `busy=1`, and `in_ready` remaining 1.
- **Reset mid-word:** pull `rst_n` low at `bit_idx=7` of `16'hACF0`. All outputs take reset values immediately; after release the block stays IDLE until a new handshake.
